// File: rtl/uart_rx_ctrl_pkg.sv
// Shared types for the uart_rx_ctrl slice: controller state encoding and the
// layout of one received word as stored in the receive FIFO.
package uart_pkg;

  localparam int unsigned RX_DATA_BITS = 8;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    HUNT = 2'd1,
    RUN  = 2'd2
  } rx_ctrl_state_e;

  typedef struct packed {
    logic                    frame_err;
    logic                    parity_err;
    logic [RX_DATA_BITS-1:0] data;
  } rx_word_t;

endpackage

// File: rtl/uart_rx_ctrl_fifo.sv
// uart_sync_fifo: first-word-fall-through synchronous FIFO with occupancy count.
// A push while full is accepted only when a pop happens in the same cycle.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH = $bits(rx_word_t),
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic                       full_o,
  output logic                       valid_o,
  output logic [WIDTH-1:0]           head_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $fatal(1, "uart_sync_fifo: DEPTH must be a power of two >= 2");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, rd_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign valid_o = (count_q != '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop_i & valid_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign head_o  = valid_o ? mem_q[rd_q] : '0;
  assign count_o = count_q;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_q] <= push_data_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PTR_W'(1);
      if (do_pop)  rd_q <= rd_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: pad synchroniser, 16x tick generator, idle-hunt FSM and receive FIFO
// in front of a uart_rx core. Define UART_RX_CTRL_ERR_DROP_EN to discard errored words.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = RX_DATA_BITS,
  parameter int unsigned OVS_FACTOR = 16,
  parameter int unsigned DIV_WIDTH  = 16,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            cfg_rx_en,
  input  logic                            cfg_parity_en,
  input  logic [DIV_WIDTH-1:0]            baud_div,
  input  logic                            rx_pad,
  output logic                            core_reset,
  output logic                            core_tick_16x,
  output logic                            core_rx_pin,
  output logic                            core_parity_en,
  input  logic [DATA_BITS-1:0]            core_rx_data,
  input  logic                            core_data_ready,
  input  logic                            core_parity_err,
  input  logic                            core_frame_err,
  output logic                            rd_valid,
  input  logic                            rd_ready,
  output logic [DATA_BITS-1:0]            rd_data,
  output logic                            rd_parity_err,
  output logic                            rd_frame_err,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic                            overrun,
  input  logic                            clr_overrun,
  output logic                            irq
`ifdef UART_RX_CTRL_ERR_DROP_EN
  ,
  output logic [7:0]                      err_drop_count
`endif
);

  localparam logic [1:0] ST_OFF  = OFF;
  localparam logic [1:0] ST_HUNT = HUNT;
  localparam logic [1:0] ST_RUN  = RUN;

  localparam int unsigned HUNT_TICKS = OVS_FACTOR * (DATA_BITS + 3);
  localparam int unsigned HUNT_W     = $clog2(HUNT_TICKS + 1);
  localparam int unsigned WORD_W     = DATA_BITS + 2;

  logic                 sync1_q, sync2_q;
  logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;
  logic [1:0]           state_q, state_d;
  logic [HUNT_W-1:0]    hunt_cnt_q, hunt_cnt_d;
  logic                 core_reset_q, parity_q, ready_prev_q, overrun_q;
  logic                 tick, push_req, fifo_push, fifo_pop, fifo_full;
  logic [WORD_W-1:0]    fifo_head;

  assign tick           = (state_q != ST_OFF) && (div_cnt_q >= baud_div);
  assign core_tick_16x  = tick;
  assign core_rx_pin    = sync2_q;
  assign core_reset     = core_reset_q;
  assign core_parity_en = parity_q;

  always_comb begin
    div_cnt_d = div_cnt_q + DIV_WIDTH'(1);
    if (state_q == ST_OFF || tick) begin
      div_cnt_d = '0;
    end
  end

  // The line must stay idle for a full frame's worth of ticks before the core is released.
  always_comb begin
    state_d    = state_q;
    hunt_cnt_d = hunt_cnt_q;
    case (state_q)
      ST_OFF: begin
        hunt_cnt_d = '0;
        if (cfg_rx_en) state_d = ST_HUNT;
      end
      ST_HUNT: begin
        if (!sync2_q) begin
          hunt_cnt_d = '0;
        end else if (tick) begin
          if (hunt_cnt_q == HUNT_W'(HUNT_TICKS - 1)) begin
            hunt_cnt_d = '0;
            state_d    = ST_RUN;
          end else begin
            hunt_cnt_d = hunt_cnt_q + HUNT_W'(1);
          end
        end
      end
      ST_RUN:  hunt_cnt_d = '0;
      default: begin
        hunt_cnt_d = '0;
        state_d    = ST_OFF;
      end
    endcase
    if (!cfg_rx_en) state_d = ST_OFF;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      div_cnt_q    <= '0;
      state_q      <= ST_OFF;
      hunt_cnt_q   <= '0;
      core_reset_q <= 1'b1;
      parity_q     <= 1'b0;
      ready_prev_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      sync1_q      <= rx_pad;
      sync2_q      <= sync1_q;
      div_cnt_q    <= div_cnt_d;
      state_q      <= state_d;
      hunt_cnt_q   <= hunt_cnt_d;
      core_reset_q <= (state_d != ST_RUN);
      ready_prev_q <= core_data_ready;
      if (state_q == ST_OFF && cfg_rx_en) parity_q <= cfg_parity_en;
      overrun_q    <= (fifo_push & fifo_full & ~fifo_pop) | (overrun_q & ~clr_overrun);
    end
  end

  assign push_req = core_data_ready & ~ready_prev_q & (state_q == ST_RUN);
  assign fifo_pop = rd_valid & rd_ready;

`ifdef UART_RX_CTRL_ERR_DROP_EN
  logic       has_err;
  logic [7:0] drop_cnt_q;

  assign has_err        = core_parity_err | core_frame_err;
  assign fifo_push      = push_req & ~has_err;
  assign err_drop_count = drop_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_cnt_q <= '0;
    end else if (clr_overrun) begin
      drop_cnt_q <= '0;
    end else if (push_req && has_err && drop_cnt_q != 8'hFF) begin
      drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end
`else
  assign fifo_push = push_req;
`endif

  uart_sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (fifo_push),
    .push_data_i ({core_frame_err, core_parity_err, core_rx_data}),
    .pop_i       (fifo_pop),
    .full_o      (fifo_full),
    .valid_o     (rd_valid),
    .head_o      (fifo_head),
    .count_o     (fifo_count)
  );

  assign rd_data       = fifo_head[DATA_BITS-1:0];
  assign rd_parity_err = fifo_head[DATA_BITS];
  assign rd_frame_err  = fifo_head[DATA_BITS+1];
  assign overrun       = overrun_q;
  assign irq           = rd_valid | overrun_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: directed tick/hunt checks plus a queue-based receive model
// with a free-running monitor that checks every FIFO output cycle by cycle.
module tb_uart_rx_ctrl;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cfg_rx_en = 1'b0;
  logic        cfg_parity_en = 1'b0;
  logic [15:0] baud_div = 16'd0;
  logic        rx_pad = 1'b1;
  logic        core_reset, core_tick_16x, core_rx_pin, core_parity_en;
  logic [7:0]  core_rx_data = 8'd0;
  logic        core_data_ready = 1'b0;
  logic        core_parity_err = 1'b0;
  logic        core_frame_err = 1'b0;
  logic        rd_valid;
  logic        rd_ready = 1'b0;
  logic [7:0]  rd_data;
  logic        rd_parity_err, rd_frame_err;
  logic [3:0]  fifo_count;
  logic        overrun;
  logic        clr_overrun = 1'b0;
  logic        irq;
`ifdef UART_RX_CTRL_ERR_DROP_EN
  logic [7:0]  err_drop_count;
`endif

  uart_rx_ctrl dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .cfg_rx_en       (cfg_rx_en),
    .cfg_parity_en   (cfg_parity_en),
    .baud_div        (baud_div),
    .rx_pad          (rx_pad),
    .core_reset      (core_reset),
    .core_tick_16x   (core_tick_16x),
    .core_rx_pin     (core_rx_pin),
    .core_parity_en  (core_parity_en),
    .core_rx_data    (core_rx_data),
    .core_data_ready (core_data_ready),
    .core_parity_err (core_parity_err),
    .core_frame_err  (core_frame_err),
    .rd_valid        (rd_valid),
    .rd_ready        (rd_ready),
    .rd_data         (rd_data),
    .rd_parity_err   (rd_parity_err),
    .rd_frame_err    (rd_frame_err),
    .fifo_count      (fifo_count),
    .overrun         (overrun),
    .clr_overrun     (clr_overrun),
    .irq             (irq)
`ifdef UART_RX_CTRL_ERR_DROP_EN
    ,
    .err_drop_count  (err_drop_count)
`endif
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad = 0;
  logic [9:0] expQ [$];
  bit         expOverrun = 0;
  int         expDrop = 0;
  bit         pushNow = 0;
  logic [9:0] pushWord = '0;
  bit         clrNow = 0;
  int         hostMode = 0;
  bit         checkEn = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One-cycle data_ready pulse from the core; caller leaves a low cycle before the next one.
  task automatic applyStimulus(input logic [7:0] d, input bit pe, input bit fe);
    core_rx_data    = d;
    core_parity_err = pe;
    core_frame_err  = fe;
    core_data_ready = 1'b1;
    pushWord        = {fe, pe, d};
    pushNow         = 1'b1;
    cyc();
    core_data_ready = 1'b0;
    pushNow         = 1'b0;
  endtask

  task automatic pulseClear();
    clr_overrun = 1'b1;
    clrNow      = 1'b1;
    cyc();
    clr_overrun = 1'b0;
    clrNow      = 1'b0;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_core_reset"}, core_reset, 1);
    checkOutput({tag, "_tick"}, core_tick_16x, 0);
    checkOutput({tag, "_rx_pin"}, core_rx_pin, 1);
    checkOutput({tag, "_parity_en"}, core_parity_en, 0);
    checkOutput({tag, "_rd_valid"}, rd_valid, 0);
    checkOutput({tag, "_rd_word"}, {rd_frame_err, rd_parity_err, rd_data}, 0);
    checkOutput({tag, "_fifo_count"}, fifo_count, 0);
    checkOutput({tag, "_overrun"}, overrun, 0);
    checkOutput({tag, "_irq"}, irq, 0);
`ifdef UART_RX_CTRL_ERR_DROP_EN
    checkOutput({tag, "_err_drop"}, err_drop_count, 0);
`endif
  endtask

  // Reference receive path: a word is kept if there is room after this cycle's pop.
  initial begin
    bit setOv;
    forever begin
      @(posedge clk);
      #3;
      if (checkEn) begin
        setOv = 0;
        if (pushNow) begin
`ifdef UART_RX_CTRL_ERR_DROP_EN
          if (pushWord[9] || pushWord[8]) begin
            if (!clrNow && expDrop < 255) expDrop++;
          end else
`endif
          if (expQ.size() < DEPTH) expQ.push_back(pushWord);
          else setOv = 1;
        end
`ifdef UART_RX_CTRL_ERR_DROP_EN
        if (clrNow) expDrop = 0;
`endif
        if (setOv) expOverrun = 1;
        else if (clrNow) expOverrun = 0;
      end
    end
  end

  // Host side: drives rd_ready and checks every visible FIFO output each cycle.
  initial begin
    logic [9:0] w;
    forever begin
      @(posedge clk);
      #2;
      if (!checkEn) begin
        rd_ready = 1'b0;
      end else begin
        rd_ready = (hostMode == 2) ? 1'b1 : (hostMode == 1) ? ($urandom_range(0, 1) == 1) : 1'b0;
        checkOutput("mon_rd_valid", rd_valid, expQ.size() != 0);
        checkOutput("mon_fifo_count", fifo_count, expQ.size());
        checkOutput("mon_overrun", overrun, expOverrun);
        checkOutput("mon_irq", irq, (expQ.size() != 0) || expOverrun);
`ifdef UART_RX_CTRL_ERR_DROP_EN
        checkOutput("mon_err_drop", err_drop_count, expDrop);
`endif
        if (rd_valid && rd_ready) begin
          if (expQ.size() == 0) begin
            checkOutput("mon_unexpected_pop", rd_valid, 0);
          end else begin
            w = expQ.pop_front();
            checkOutput("mon_rd_word", {rd_frame_err, rd_parity_err, rd_data}, w);
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    bad++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int         n, last, glitchAt;
    logic [7:0] words [9];
    logic [7:0] d;

    #12;
    checkResetValues("reset");
    @(negedge clk);
    reset_n = 1'b1;
    cyc();

    $display("[TB] tick generator");
    baud_div  = 16'd3;
    cfg_rx_en = 1'b1;
    n = 0;
    last = -1;
    for (int i = 0; i < 24; i++) begin
      cyc();
      if (core_tick_16x) begin
        if (last >= 0) checkOutput("tick_period_div3", i - last, 4);
        last = i;
        n++;
      end
    end
    checkOutput("tick_count_div3", n, 6);
    baud_div = 16'd0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      checkOutput("tick_div0", core_tick_16x, 1);
    end
    cfg_rx_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      checkOutput("tick_disabled", core_tick_16x, 0);
    end

    $display("[TB] idle hunt");
    cfg_parity_en = 1'b1;
    cfg_rx_en     = 1'b1;
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      cyc();
      if (!core_reset) break;
      if (core_tick_16x) n++;
    end
    checkOutput("hunt_released", core_reset, 0);
    checkOutput("hunt_ticks", n, 176);
    checkOutput("parity_latched", core_parity_en, 1);
    cfg_rx_en = 1'b0;
    cyc();
    cyc();
    checkOutput("disable_core_reset", core_reset, 1);

    // A single low sample after 50 ticks reaches the core pin two cycles later and restarts the count.
    cfg_rx_en = 1'b1;
    n = 0;
    glitchAt = -1;
    for (int i = 0; i < 1000; i++) begin
      cyc();
      if (!core_reset) break;
      if (core_tick_16x) n++;
      if (n == 50 && glitchAt < 0) begin
        rx_pad = 1'b0;
        glitchAt = i;
      end else if (glitchAt >= 0 && i == glitchAt + 1) begin
        rx_pad = 1'b1;
      end
    end
    checkOutput("hunt_restart_released", core_reset, 0);
    checkOutput("hunt_restart_ticks", n, 228);

    $display("[TB] single word");
    checkEn  = 1'b1;
    hostMode = 0;
    cyc();
    applyStimulus(8'hA5, 1'b0, 1'b0);
    checkOutput("first_rd_valid", rd_valid, 1);
    checkOutput("first_rd_data", rd_data, 8'hA5);
    checkOutput("first_flags", {rd_frame_err, rd_parity_err}, 0);
    checkOutput("first_count", fifo_count, 1);
    checkOutput("first_irq", irq, 1);
    hostMode = 2;
    cyc();
    checkOutput("first_popped_count", fifo_count, 0);
    checkOutput("first_popped_irq", irq, 0);
    hostMode = 0;
    cyc();

    $display("[TB] overflow");
    for (int i = 0; i < 9; i++) begin
      words[i] = 8'($urandom);
      applyStimulus(words[i], 1'b0, 1'b0);
      cyc();
    end
    checkOutput("full_count", fifo_count, 8);
    checkOutput("full_overrun", overrun, 1);
    checkOutput("full_head", rd_data, words[0]);
    pulseClear();
    checkOutput("overrun_cleared", overrun, 0);
    hostMode = 2;
    applyStimulus(8'h3E, 1'b0, 1'b0);
    checkOutput("push_pop_full_count", fifo_count, 8);
    checkOutput("push_pop_full_overrun", overrun, 0);

    $display("[TB] error flags");
    for (int i = 0; i < 50 && expQ.size() != 0; i++) cyc();
    checkOutput("drained_count", fifo_count, 0);
    hostMode = 0;
    cyc();
    applyStimulus(8'h3C, 1'b0, 1'b1);
`ifdef UART_RX_CTRL_ERR_DROP_EN
    checkOutput("frame_err_dropped_count", fifo_count, 0);
    checkOutput("frame_err_drop_counter", err_drop_count, 1);
`else
    checkOutput("frame_err_flag", rd_frame_err, 1);
    checkOutput("frame_err_parity_flag", rd_parity_err, 0);
    checkOutput("frame_err_data", rd_data, 8'h3C);
`endif
    cyc();
    applyStimulus(8'h5A, 1'b1, 1'b0);
    cyc();

    $display("[TB] random traffic");
    for (int it = 0; it < 400; it++) begin
      if (it % 50 == 0) hostMode = $urandom_range(0, 2);
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: begin
          d = 8'($urandom);
          applyStimulus(d, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
          cyc();
        end
        9:       pulseClear();
        default: cyc();
      endcase
    end

    $display("[TB] reset mid-frame");
    hostMode = 2;
    for (int i = 0; i < 50 && expQ.size() != 0; i++) cyc();
    hostMode = 0;
    pulseClear();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(8'(8'h10 + i), 1'b0, 1'b0);
      cyc();
    end
    checkOutput("queued_three", fifo_count, 3);
    checkEn = 1'b0;
    core_data_ready = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    checkResetValues("async_reset");
    expQ.delete();
    expOverrun = 0;
    expDrop = 0;
    core_data_ready = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    cyc();
    checkOutput("post_reset_count", fifo_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
